// File: rtl/dcm_reset_seq.sv
// DCM reset/lock sequencer: pulses DCM RST, waits for a stable LOCKED, then releases the
// system reset. Runs on CLKIN so it keeps sequencing while the DCM output clock is absent.
module dcm_reset_seq #(
   parameter int unsigned DCM_RST_CYCLES = 3,
   parameter int unsigned LOCK_TIMEOUT   = 65535,
   parameter int unsigned SETTLE_CYCLES  = 256,
   parameter int unsigned CNT_W          = 16
) (
   input  logic       CLKIN,
   input  logic       RST,
   input  logic       LOCKED,
   input  logic       STATUS,
   output logic       DCM_RST,
   output logic       RESET_OUT,
   output logic       READY,
   output logic [3:0] RETRY_COUNT,
   output logic       FAULT
);

   localparam logic [CNT_W-1:0] RstLast     = CNT_W'(DCM_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [3:0] {
      StDcmRst   = 4'b0001,
      StWaitLock = 4'b0010,
      StSettle   = 4'b0100,
      StRun      = 4'b1000
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic             fault_q, fault_d;
   logic             lock_meta_q, lock_s_q;
   logic             stat_meta_q, stat_s_q;
   logic             do_retry;

   always_ff @(posedge CLKIN or posedge RST) begin
      if (RST) begin
         state_q     <= StDcmRst;
         cnt_q       <= '0;
         retry_q     <= '0;
         fault_q     <= 1'b0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         stat_meta_q <= 1'b0;
         stat_s_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         fault_q     <= fault_d;
         lock_meta_q <= LOCKED;
         lock_s_q    <= lock_meta_q;
         stat_meta_q <= STATUS;
         stat_s_q    <= stat_meta_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      retry_d  = retry_q;
      fault_d  = fault_q;
      do_retry = 1'b0;
      unique case (state_q)
         StDcmRst: begin
            if (cnt_q == RstLast) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // STATUS is deliberately ignored while waiting for the first lock.
         StWaitLock: begin
            if (lock_s_q) begin
               state_d = StSettle;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               do_retry = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StSettle: begin
            if (!lock_s_q || stat_s_q) begin
               do_retry = 1'b1;
            end else if (cnt_q == SettleLast) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRun: begin
            if (!lock_s_q || stat_s_q) do_retry = 1'b1;
         end
         default: begin
            state_d = StDcmRst;
            cnt_d   = '0;
         end
      endcase
      if (do_retry) begin
         state_d = StDcmRst;
         cnt_d   = '0;
         if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
         if (retry_d == 4'hF) fault_d = 1'b1;
      end
   end

   always_comb begin
      DCM_RST     = (state_q == StDcmRst);
      RESET_OUT   = (state_q != StRun);
      READY       = (state_q == StRun);
      RETRY_COUNT = retry_q;
      FAULT       = fault_q;
   end

endmodule
